// File: rtl/wide_serializer_if.sv
// Word-in / beat-out handshake bundle for wide_serializer.
interface wide_serializer_if #(
    parameter int DATA_WIDTH = 480,
    parameter int CTRL_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
);
    logic [DATA_WIDTH-1:0] in_data;
    logic [CTRL_WIDTH-1:0] in_ctl;
    logic                  datavalid;
    logic                  in_rdy;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_wr;
    logic                  out_last;
    logic                  out_rdy;

    modport master (
        output in_data, in_ctl, datavalid, out_rdy,
        input  in_rdy, out_data, out_wr, out_last
    );

    modport slave (
        input  in_data, in_ctl, datavalid, out_rdy,
        output in_rdy, out_data, out_wr, out_last
    );
endinterface

// File: rtl/wide_serializer.sv
// Serializes a wide word into MSB-first beats with per-word length
// and end-of-packet marking; reloads on the final beat with no bubble.
module wide_serializer #(
    parameter int DATA_WIDTH = 480,
    parameter int CTRL_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    wide_serializer_if.slave  bus
);
    localparam int N  = DATA_WIDTH / OUT_WIDTH;
    localparam int CW = $clog2(N) + 1;

    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [CW-1:0]         r_cnt;
    logic [CW-1:0]         w_cnt_nxt;
    logic [CW-1:0]         r_len;
    logic [CW-1:0]         w_len_nxt;
    logic [CW-1:0]         w_eff_len;
    logic                  r_eop;
    logic                  w_eop_nxt;
    logic                  r_last;
    logic                  w_last_nxt;
    logic                  w_fire_in;
    logic                  w_fire_out;
    logic                  w_final;
    logic [15:0]           w_ctl_len;
    logic                  w_unused_ctl;

    // A zero or oversized length means "the whole word".
    assign w_ctl_len = bus.in_ctl[15:0];
    assign w_eff_len = (w_ctl_len == 16'd0 || w_ctl_len > 16'(N))
                       ? CW'(N) : w_ctl_len[CW-1:0];
    assign w_unused_ctl = ^bus.in_ctl[CTRL_WIDTH-2:16];

    assign w_final    = (r_cnt == r_len - CW'(1));
    assign bus.in_rdy = (r_state == IDLE)
                     || (r_state == SEND && w_final && bus.out_rdy);
    assign w_fire_in  = bus.datavalid && bus.in_rdy;
    assign w_fire_out = (r_state == SEND) && bus.out_rdy;

    assign bus.out_wr   = (r_state == SEND);
    assign bus.out_data = r_shift[DATA_WIDTH-1 -: OUT_WIDTH];
    assign bus.out_last = r_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_eop   <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_eop   <= w_eop_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_fire_in) w_state_nxt = SEND;
            SEND: if (w_fire_out && w_final && !w_fire_in) w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        w_eop_nxt   = r_eop;
        w_last_nxt  = r_last;
        if (w_fire_in) begin
            w_shift_nxt = bus.in_data;
            w_cnt_nxt   = '0;
            w_len_nxt   = w_eff_len;
            w_eop_nxt   = bus.in_ctl[CTRL_WIDTH-1];
            w_last_nxt  = bus.in_ctl[CTRL_WIDTH-1] && (w_eff_len == CW'(1));
        end else if (w_fire_out && w_final) begin
            w_shift_nxt = '0;
            w_cnt_nxt   = '0;
            w_last_nxt  = 1'b0;
        end else if (w_fire_out) begin
            w_shift_nxt = r_shift << OUT_WIDTH;
            w_cnt_nxt   = r_cnt + CW'(1);
            // Flag the next beat if it will be the word's last.
            w_last_nxt  = r_eop && (r_cnt + CW'(1) == r_len - CW'(1));
        end
    end
endmodule

// File: tb/tb_wide_serializer.sv
// Randomized bench for wide_serializer against a beat-queue model.
module tb_wide_serializer;
    localparam int DW = 480;
    localparam int CW = 32;
    localparam int OW = 8;
    localparam int N  = DW / OW;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [8:0] q[$];

    always #5 clk = ~clk;

    wide_serializer_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .OUT_WIDTH(OW)) bus ();

    wide_serializer #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .OUT_WIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic int eff_len(input logic [31:0] c);
        int l;
        l = int'(c[15:0]);
        if (l == 0 || l > N) l = N;
        return l;
    endfunction

    // Model: every accepted word becomes a list of expected beats.
    function automatic void push_word(input logic [DW-1:0] d, input logic [31:0] c);
        int l;
        logic [DW-1:0] s;
        l = eff_len(c);
        for (int k = 0; k < l; k++) begin
            s = d >> (DW - OW * (k + 1));
            q.push_back({c[31] && (k == l - 1), s[7:0]});
        end
    endfunction

    task automatic tick(input logic [DW-1:0] d, input logic [31:0] c,
                        input logic dv, input logic ordy,
                        output logic [10:0] obs, output logic [10:0] exp);
        @(negedge clk);
        bus.in_data   = d;
        bus.in_ctl    = c;
        bus.datavalid = dv;
        bus.out_rdy   = ordy;
        #1;
        obs = {bus.in_rdy, bus.out_wr, bus.out_last, bus.out_data};
        if (q.size() == 0) exp = 11'h400;
        else exp = {(q.size() == 1) && ordy, 1'b1, q[0][8], q[0][7:0]};
        if (exp[9] && ordy) void'(q.pop_front());
        if (dv && exp[10]) push_word(d, c);
    endtask

    task automatic test_reset();
        logic [10:0] obs, exp;
        rst = 1'b0;
        bus.in_data = '0;
        bus.in_ctl = '0;
        bus.datavalid = 1'b0;
        bus.out_rdy = 1'b0;
        #3;
        obs = {bus.in_rdy, bus.out_wr, bus.out_last, bus.out_data};
        checks++;
        if (obs !== 11'h400) begin
            errors++;
            $display("FAIL reset_async got %h want %h", obs, 11'h400);
        end
        for (int i = 0; i < 3; i++) begin
            tick(rand_word(), 32'd5, 1'b0, 1'b1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %h want %h", i, obs, exp);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_full_word();
        logic [10:0] obs, exp;
        logic [DW-1:0] d;
        logic [31:0] c;
        int nb;
        d = rand_word();
        d[DW-1 -: 8] = 8'hA5;
        d[7:0] = 8'h3C;
        c = {1'b1, 15'd0, 16'd60};
        nb = 0;
        tick(d, c, 1'b1, 1'b1, obs, exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL full_accept got %h want %h", obs, exp);
        end
        for (int i = 0; i < 62; i++) begin
            tick(rand_word(), 32'd0, 1'b0, 1'b1, obs, exp);
            if (obs[9]) nb++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL full_beat %0d got %h want %h", i, obs, exp);
            end
        end
        checks++;
        if (nb !== 60) begin
            errors++;
            $display("FAIL full_count got %0d want 60", nb);
        end
    endtask

    task automatic test_lengths();
        logic [10:0] obs, exp;
        logic [31:0] c;
        int lens[7] = '{3, 0, 100, 1, 60, 61, 2};
        int nb;
        foreach (lens[j]) begin
            c = {1'($urandom), 15'd0, 16'(lens[j])};
            nb = 0;
            tick(rand_word(), c, 1'b1, 1'b1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL len_accept %0d got %h want %h", lens[j], obs, exp);
            end
            for (int i = 0; i < eff_len(c) + 2; i++) begin
                tick(rand_word(), 32'd0, 1'b0, 1'b1, obs, exp);
                if (obs[9]) nb++;
                checks++;
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL len_%0d beat %0d got %h want %h", lens[j], i, obs, exp);
                end
            end
            checks++;
            if (nb !== eff_len(c)) begin
                errors++;
                $display("FAIL len_%0d count got %0d want %0d", lens[j], nb, eff_len(c));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] obs, exp;
        logic [DW-1:0] w[3];
        logic [31:0] c;
        logic dv;
        int wi, run;
        c = {1'b1, 15'd0, 16'd4};
        foreach (w[i]) w[i] = rand_word();
        wi = 0;
        run = 0;
        for (int i = 0; i < 16; i++) begin
            dv = (wi < 3);
            tick(w[dv ? wi : 0], c, dv, 1'b1, obs, exp);
            if (i >= 1 && i <= 12 && obs[9]) run++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL b2b cyc %0d got %h want %h", i, obs, exp);
            end
            if (dv && exp[10]) wi++;
        end
        checks++;
        if (run !== 12) begin
            errors++;
            $display("FAIL b2b_run got %0d want 12", run);
        end
    endtask

    task automatic test_backpressure();
        logic [10:0] obs, exp;
        logic [DW-1:0] d;
        logic [31:0] c;
        logic ordy, dv;
        int wi, total, sent, cyc;
        d = rand_word();
        c = {1'b1, 15'd0, 16'($urandom_range(1, 8))};
        wi = 0;
        total = 0;
        sent = 0;
        cyc = 0;
        while ((wi < 4 || q.size() != 0) && cyc < 400) begin
            ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
            dv = (wi < 4);
            tick(d, c, dv, ordy, obs, exp);
            if (obs[9] && ordy) sent++;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL bp cyc %0d got %h want %h", cyc, obs, exp);
            end
            if (dv && exp[10]) begin
                total += eff_len(c);
                wi++;
                d = rand_word();
                c = {1'($urandom), 15'd0, 16'($urandom_range(1, 8))};
            end
            cyc++;
        end
        checks++;
        if (wi !== 4 || sent !== total) begin
            errors++;
            $display("FAIL bp_total words %0d sent %0d want 4 words %0d beats", wi, sent, total);
        end
    endtask

    task automatic test_reset_mid();
        logic [10:0] obs, exp;
        tick(rand_word(), {1'b1, 15'd0, 16'd60}, 1'b1, 1'b1, obs, exp);
        for (int i = 0; i < 10; i++) begin
            tick(rand_word(), 32'd0, 1'b0, 1'b1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_pre beat %0d got %h want %h", i, obs, exp);
            end
        end
        #2 rst = 1'b0;
        #1;
        obs = {bus.in_rdy, bus.out_wr, bus.out_last, bus.out_data};
        checks++;
        if (obs !== 11'h400) begin
            errors++;
            $display("FAIL mid_async got %h want %h", obs, 11'h400);
        end
        q.delete();
        for (int i = 0; i < 2; i++) begin
            tick(rand_word(), 32'd0, 1'b0, 1'b1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_hold cyc %0d got %h want %h", i, obs, exp);
            end
        end
        rst = 1'b1;
        tick(rand_word(), {1'b1, 15'd0, 16'd2}, 1'b1, 1'b1, obs, exp);
        for (int i = 0; i < 4; i++) begin
            tick(rand_word(), 32'd0, 1'b0, 1'b1, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mid_post cyc %0d got %h want %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] obs, exp;
        logic [DW-1:0] d;
        logic [31:0] c;
        logic dv, ordy;
        d = rand_word();
        c = {1'($urandom), 15'd0, 16'($urandom_range(0, 70))};
        for (int i = 0; i < 1500; i++) begin
            dv = 1'($urandom);
            ordy = ($urandom % 4) != 0;
            tick(d, c, dv, ordy, obs, exp);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL rand cyc %0d got %h want %h", i, obs, exp);
            end
            if (dv && exp[10]) begin
                d = rand_word();
                c = {1'($urandom), 15'd0, 16'($urandom_range(0, 70))};
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_lengths();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
